// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between an instruction fetch
// port and a data (read/write) port. Data normally wins arbitration; a fetch
// waiting through STARVE_MAX consecutive data grants is then served first.
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   iREN, iaddr        fetch request (held until ihit) and word address
//   dREN, dWEN         data read / write request (held until dhit)
//   daddr, dstore      data address and write data
//   ram_ready, ramload RAM completion strobe and read data
//   ramREN, ramWEN     RAM read / write strobes
//   ramaddr, ramstore  RAM address and write data
//   ihit, iload        fetch completion and fetched word (same cycle as ram_ready)
//   dhit, dload        data completion and loaded word (same cycle as ram_ready)
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    input  logic        ram_ready,
    input  logic [31:0] ramload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    // Latched request presented to the RAM for the whole busy period
    typedef struct packed {
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] store;
    } req_t;

    state_t        state_q, state_d;
    req_t          req_q, req_d;
    logic [SW-1:0] streak_q, streak_d;
    logic          dropped_q, dropped_d;

    logic d_req;
    logic starve;
    logic owner_req;
    logic owner_live;

    // State and request registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            req_q     <= '0;
            streak_q  <= '0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            streak_q  <= streak_d;
            dropped_q <= dropped_d;
        end
    end

    // Arbitration and next-state logic
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        streak_d   = streak_q;
        dropped_d  = dropped_q;
        d_req      = dREN | dWEN;
        starve     = iREN && (streak_q == SW'(STARVE_MAX));
        owner_req  = (state_q == IBUSY) ? iREN : d_req;
        // A requester that let go once during the access never gets its hit
        owner_live = owner_req & ~dropped_q;

        case (state_q)
            IDLE: begin
                dropped_d = 1'b0;
                if (d_req && !starve) begin
                    state_d     = DBUSY;
                    req_d.wen   = dWEN;       // read+write together is a write
                    req_d.addr  = daddr;
                    req_d.store = dWEN ? dstore : '0;
                    if (!iREN) begin
                        streak_d = '0;
                    end else if (streak_q != SW'(STARVE_MAX)) begin
                        streak_d = streak_q + SW'(1);
                    end
                end else if (iREN) begin
                    state_d     = IBUSY;
                    req_d.wen   = 1'b0;
                    req_d.addr  = iaddr;
                    req_d.store = '0;
                    streak_d    = '0;
                end
            end
            IBUSY, DBUSY: begin
                if (ram_ready) begin
                    state_d = IDLE;
                end else begin
                    dropped_d = dropped_q | ~owner_req;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM side and hit outputs; hits are masked while reset is asserted
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        dhit     = 1'b0;
        iload    = '0;
        dload    = '0;

        case (state_q)
            IBUSY: begin
                ramREN  = 1'b1;
                ramaddr = req_q.addr;
                ihit    = ram_ready & owner_live & ~RST;
                iload   = ihit ? ramload : '0;
            end
            DBUSY: begin
                ramREN   = ~req_q.wen;
                ramWEN   = req_q.wen;
                ramaddr  = req_q.addr;
                ramstore = req_q.wen ? req_q.store : '0;
                dhit     = ram_ready & owner_live & ~RST;
                dload    = (dhit && !req_q.wen) ? ramload : '0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, meaning: the number of consecutive data grants allowed while a fetch is pending; legal range 1..15.
REQ-002 CLK  input  1  system clock; all state updates on the rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 iREN  input  1  instruction fetch request, held until ihit.
REQ-005 iaddr  input  32  fetch word address.
REQ-006 dREN  input  1  data read request, held until dhit.
REQ-007 dWEN  input  1  data write request, held until dhit; never asserted together with dREN.
REQ-008 daddr  input  32  data address.
REQ-009 dstore  input  32  write data.
REQ-010 ram_ready  input  1  the RAM completes the presented access this cycle.
REQ-011 ramload  input  32  RAM read data, valid when ram_ready=1.
REQ-012 ramREN  output  1  RAM read strobe.
REQ-013 ramWEN  output  1  RAM write strobe.
REQ-014 ramaddr  output  32  RAM address.
REQ-015 ramstore  output  32  RAM write data.
REQ-016 ihit  output  1  fetch completes this cycle.
REQ-017 dhit  output  1  data access completes this cycle.
REQ-018 iload  output  32  fetched instruction, valid when ihit=1.
REQ-019 dload  output  32  loaded data, valid when dhit=1 for a read.

Function
REQ-020 FSM states: IDLE, IBUSY, DBUSY. Only one access is ever presented to the RAM at a time.
REQ-021 IDLE behaviour:
- ramREN=ramWEN=0, ihit=dhit=0.
- Arbitrate on the current inputs and latch the winner's op, address and store data into request registers.
- Next state is IBUSY or DBUSY according to the winner.
- No requests: remain in IDLE.
REQ-022 Arbitration: data wins over fetch, except when iREN=1 and streak==STARVE_MAX; in that case fetch wins.
REQ-023 streak counter (4 bits):
- +1 on each data grant made while iREN=1.
- Cleared on any fetch grant.
- Cleared on any data grant made while iREN=0.
- Saturates at STARVE_MAX.
REQ-024 IBUSY/DBUSY outputs: ramREN/ramWEN/ramaddr/ramstore are driven only from the latched request registers, never from live inputs.
REQ-025 In IBUSY/DBUSY with ram_ready=0: hold state; hits stay 0.
REQ-026 In IBUSY with ram_ready=1:
- ihit=1 and iload=ramload in the same cycle, combinationally.
- Next state IDLE.
REQ-027 In DBUSY with ram_ready=1:
- dhit=1 in the same cycle.
- dload=ramload for a read.
- Next state IDLE.
REQ-028 Minimum latency from request to hit is 1 cycle: request seen in IDLE at cycle N, hit at cycle N+1 if ram_ready=1. There is always one IDLE cycle between back-to-back accesses.
REQ-029 Requester drops its request while busy: the RAM access still completes. The matching hit is suppressed (forced 0) and the FSM returns to IDLE on ram_ready.
REQ-030 Request input changes while busy have no effect on RAM outputs.
REQ-031 Outputs not in use: iload=0 when ihit=0; dload=0 when dhit=0; ramstore=0 unless ramWEN=1; ramaddr=0 in IDLE.
REQ-032 dREN and dWEN both asserted is illegal. The block treats it as a write.

Reset
REQ-033 RST=1 at a clock edge forces:
- state=IDLE, streak=0, request registers=0.
- All outputs 0 in the following cycle.
REQ-034 RST asserted while busy aborts the access. No hit is produced for it.
REQ-035 RST has priority over ram_ready in the same cycle.

Verification
REQ-036 Fetch only: iREN=1, iaddr=0x40, ram_ready=1 from the cycle after the request:
- ramREN=1 with ramaddr=0x40 one cycle after the request.
- ihit=1 with iload=ramload in that same cycle.
- FSM returns to IDLE.
REQ-037 Simultaneous requests: iREN=1 and dREN=1 (daddr=0x80) in the same cycle, streak=0:
- Data is served first (ramaddr=0x80, dhit).
- Fetch is granted at the next IDLE.
REQ-038 Starvation with STARVE_MAX=4: iREN held high with dREN continuously asserted:
- Exactly 4 data grants.
- Then 1 fetch grant with ihit.
- streak returns to 0.
REQ-039 Wait states: dWEN=1, daddr=0x100, dstore=0xDEADBEEF, ram_ready low for 3 cycles:
- ramWEN, ramaddr and ramstore stay stable through the wait.
- dhit only on the 4th busy cycle.
REQ-040 Reset while busy: RST=1 during DBUSY with ram_ready=1 the same cycle:
- No dhit.
- Next cycle: IDLE with all outputs 0.
REQ-041 Dropped request: iREN deasserted mid-IBUSY:
- The access completes on ram_ready.
- ihit stays 0.
- The next cycle is IDLE.
